// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target endpoint answering a fixed 7-bit address.
//               SDA/SCL are oversampled on clk: 2-flop synchroniser followed
//               by a glitch filter. The block detects START, STOP and
//               repeated START. It ACKs its address, delivers received bytes
//               with a one-cycle strobe and requests transmit bytes with a
//               one-cycle strobe. It never stretches the clock.
//
// Ports       : clk, rst        - system clock, synchronous active-high reset
//               scl_w           - I2C clock line (never driven)
//               sda_w           - I2C data line (driven 0 or released)
//               rx_ack_en       - 1 = ACK received data byte, 0 = NACK
//               write_data[7:0] - next byte to transmit
//               read_data[7:0]  - last byte received
//               rx_data_ready   - 1-clk strobe, read_data valid
//               tx_data_req     - 1-clk strobe, present next write_data
//               rw_mode         - R/W bit of current transfer (0 = WRITE)
//               selected        - addressed and active
//               stop_seen       - 1-clk strobe on every STOP
//
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        scl_w,
    inout  wire        sda_w,
    input  logic       rx_ack_en,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    output logic       rx_data_ready,
    output logic       tx_data_req,
    output logic       rw_mode,
    output logic       selected,
    output logic       stop_seen
);

    localparam logic [3:0] c_FLT_LAST = 4'(FILTER_LEN - 1);

    localparam logic c_RW_WRITE = 1'b0;
    localparam logic c_RW_READ  = 1'b1;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ADDR     = 3'd1;
    localparam logic [2:0] c_ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] c_ST_RX_BYTE  = 3'd3;
    localparam logic [2:0] c_ST_RX_ACK   = 3'd4;
    localparam logic [2:0] c_ST_TX_BYTE  = 3'd5;
    localparam logic [2:0] c_ST_TX_ACK   = 3'd6;
    localparam logic [2:0] c_ST_IGNORE   = 3'd7;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = SCL, bit 1 = SDA
    // ------------------------------------------------------------------
    logic [1:0] w_line_raw;
    logic [1:0] w_line_filt;

    assign w_line_raw = {sda_w, scl_w};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line_filter
        logic       r_sync1;
        logic       r_sync2;
        logic       r_filt;
        logic [3:0] r_cnt;

        // The filtered value only moves after FILTER_LEN consecutive
        // synchronised samples disagree with it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_filt  <= 1'b1;
                r_cnt   <= 4'd0;
            end else begin
                r_sync1 <= w_line_raw[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_filt) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == c_FLT_LAST) begin
                    r_filt <= r_sync2;
                    r_cnt  <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end

        assign w_line_filt[gi] = r_filt;
    end

    logic w_scl_f;
    logic w_sda_f;
    logic r_scl_d;
    logic r_sda_d;

    assign w_scl_f = w_line_filt[0];
    assign w_sda_f = w_line_filt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
        end
    end

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_rise = w_scl_f & ~r_scl_d;
    assign w_scl_fall = ~w_scl_f & r_scl_d;
    // SCL must be high on both samples so a simultaneous SCL/SDA move is
    // never mistaken for a bus condition.
    assign w_start    = w_scl_f & r_scl_d & r_sda_d & ~w_sda_f;
    assign w_stop     = w_scl_f & r_scl_d & ~r_sda_d & w_sda_f;

    // ------------------------------------------------------------------
    // Protocol state machine
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;     // first seven bits of the byte being received
    logic [6:0] r_tx_shift;  // bits still to be driven, next one in [6]
    logic       r_byte_done; // 8th bit seen / ACK seen, act on next fall
    logic       r_rx_ack;    // ACK decision for the byte just received
    logic       r_sda_oe;    // 1 = pull SDA low

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 7'd0;
            r_tx_shift    <= 7'd0;
            r_byte_done   <= 1'b0;
            r_rx_ack      <= 1'b0;
            r_sda_oe      <= 1'b0;
            read_data     <= 8'd0;
            rx_data_ready <= 1'b0;
            tx_data_req   <= 1'b0;
            rw_mode       <= c_RW_WRITE;
            selected      <= 1'b0;
            stop_seen     <= 1'b0;
        end else begin
            rx_data_ready <= 1'b0;
            tx_data_req   <= 1'b0;
            stop_seen     <= 1'b0;

            // Bus conditions take priority over any SCL edge in any state.
            if (w_start) begin
                r_state     <= c_ST_ADDR;
                r_bit_cnt   <= 3'd0;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
                selected    <= 1'b0;
            end else if (w_stop) begin
                r_state     <= c_ST_IDLE;
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
                selected    <= 1'b0;
                stop_seen   <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    c_ST_ADDR: begin
                        if (w_scl_rise && !r_byte_done) begin
                            r_shift <= {r_shift[5:0], w_sda_f};
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= 3'd0;
                                if (r_shift == SLAVE_ADDR) begin
                                    rw_mode     <= w_sda_f;
                                    r_byte_done <= 1'b1;
                                end else begin
                                    r_state <= c_ST_IGNORE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_sda_oe    <= 1'b1;
                            selected    <= 1'b1;
                            r_state     <= c_ST_ADDR_ACK;
                        end
                    end

                    c_ST_ADDR_ACK: begin
                        if (w_scl_rise) begin
                            if (rw_mode == c_RW_READ) begin
                                tx_data_req <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= 3'd0;
                            if (rw_mode == c_RW_READ) begin
                                r_tx_shift <= write_data[6:0];
                                r_sda_oe   <= ~write_data[7];
                                r_state    <= c_ST_TX_BYTE;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= c_ST_RX_BYTE;
                            end
                        end
                    end

                    c_ST_RX_BYTE: begin
                        if (w_scl_rise && !r_byte_done) begin
                            r_shift <= {r_shift[5:0], w_sda_f};
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt     <= 3'd0;
                                read_data     <= {r_shift, w_sda_f};
                                rx_data_ready <= 1'b1;
                                r_rx_ack      <= rx_ack_en;
                                r_byte_done   <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_sda_oe    <= r_rx_ack;
                            r_state     <= c_ST_RX_ACK;
                        end
                    end

                    c_ST_RX_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            if (r_rx_ack) begin
                                r_state <= c_ST_RX_BYTE;
                            end else begin
                                r_state  <= c_ST_IGNORE;
                                selected <= 1'b0;
                            end
                        end
                    end

                    c_ST_TX_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                // Bit 0 has been on the bus for a full
                                // clock; hand SDA to the initiator's ACK.
                                r_sda_oe    <= 1'b0;
                                r_bit_cnt   <= 3'd0;
                                r_byte_done <= 1'b0;
                                r_state     <= c_ST_TX_ACK;
                            end else begin
                                r_sda_oe   <= ~r_tx_shift[6];
                                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                                r_bit_cnt  <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    c_ST_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda_f) begin
                                tx_data_req <= 1'b1;
                                r_byte_done <= 1'b1;
                            end else begin
                                r_state  <= c_ST_IGNORE;
                                selected <= 1'b0;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_bit_cnt   <= 3'd0;
                            r_tx_shift  <= write_data[6:0];
                            r_sda_oe    <= ~write_data[7];
                            r_state     <= c_ST_TX_BYTE;
                        end
                    end

                    c_ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state  <= c_ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Open-drain outputs: SCL is never driven, SDA only pulled low.
    assign scl_w = 1'bz;
    assign sda_w = r_sda_oe ? 1'b0 : 1'bz;

endmodule
`default_nettype wire
